// File: rtl/shift_sequencer.sv
// Multi-cycle barrel-style shifter: one binary-weighted stage (1,2,4,8) per clock,
// so every non-zero shift takes the same four stage cycles regardless of amount.
module shift_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic [3:0]  in_cnt,
  input  logic [1:0]  in_op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_ROL = 2'b10;

  state_t      state;
  logic [15:0] wreg;
  logic [3:0]  cnt_q;
  logic [1:0]  op_q;
  logic [1:0]  stg;
  logic [15:0] stage_nxt;

  // One stage: shift by 2^k when enabled, otherwise pass the word through.
  function automatic logic [15:0] stage_shift(input logic [15:0] w, input logic [1:0] op,
                                              input logic [1:0] k, input logic en);
    logic [4:0]         s;
    logic signed [15:0] ws;
    logic [15:0]        r;
    s  = 5'd1 << k;
    ws = signed'(w);
    r  = w;
    if (en) begin
      case (op)
        OP_SLL:  r = w << s;
        OP_SRL:  r = w >> s;
        OP_ROL:  r = (w << s) | (w >> (5'd16 - s));
        default: r = 16'(ws >>> s);
      endcase
    end
    return r;
  endfunction

  always_comb begin
    stage_nxt = stage_shift(wreg, op_q, stg, cnt_q[stg]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wreg      <= 16'h0000;
      cnt_q     <= 4'd0;
      op_q      <= 2'b00;
      stg       <= 2'd0;
      out_data  <= 16'h0000;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            wreg     <= in_data;
            cnt_q    <= in_cnt;
            op_q     <= in_op;
            stg      <= 2'd0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (in_cnt == 4'd0) begin
              state     <= DONE;
              out_data  <= in_data;
              out_valid <= 1'b1;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          wreg <= stage_nxt;
          stg  <= stg + 2'd1;
          if (stg == 2'd3) begin
            state     <= DONE;
            out_data  <= stage_nxt;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          // Result is held until consumed; return to IDLE only, never re-accept here.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: directed vector table, random ops against an
// arithmetic reference model, backpressure and asynchronous reset sequences.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = 16'h0;
  logic [3:0]  in_cnt = 4'h0;
  logic [1:0]  in_op = 2'b00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        busy;

  int checks = 0;
  int failures = 0;

  shift_sequencer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_cnt(in_cnt), .in_op(in_op), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] data;
    logic [3:0]  cnt;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: whole-word shift by the full amount, no staging.
  function automatic logic [15:0] model(input logic [1:0] op, input logic [15:0] d,
                                        input logic [3:0] c);
    logic [31:0] dd;
    logic [31:0] rot;
    logic signed [15:0] sd;
    int n;
    n  = int'(c);
    dd = {d, d};
    sd = signed'(d);
    case (op)
      2'b00:   return d << n;
      2'b01:   return d >> n;
      2'b10:   begin rot = dd << n; return rot[31:16]; end
      default: return 16'(sd >>> n);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and wait for the result; lat counts edges after the accept edge.
  task automatic start_op(input logic [1:0] op, input logic [15:0] d, input logic [3:0] c,
                          output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin tick(); guard++; end
    if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
    in_op = op; in_data = d; in_cnt = c; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin tick(); lat++; end
    if (!out_valid) chk("valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post_handshake_valid", 32'(out_valid), 32'd0);
    chk("post_handshake_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [15:0] d,
                        input logic [3:0] c, input logic [15:0] exp);
    int lat;
    start_op(op, d, c, lat);
    chk({name, "_data"}, 32'(out_data), 32'(exp));
    chk({name, "_lat"}, 32'(lat), (c == 4'd0) ? 32'd0 : 32'd4);
    consume();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] held;
    int lat;

    tbl[0]  = '{2'b00, 16'h0001, 4'd15, 16'h8000};
    tbl[1]  = '{2'b11, 16'h8000, 4'd4,  16'hF800};
    tbl[2]  = '{2'b01, 16'hF000, 4'd12, 16'h000F};
    tbl[3]  = '{2'b10, 16'h8001, 4'd1,  16'h0003};
    tbl[4]  = '{2'b10, 16'h1234, 4'd0,  16'h1234};
    tbl[5]  = '{2'b00, 16'h1234, 4'd4,  16'h2340};
    tbl[6]  = '{2'b11, 16'h7FFF, 4'd15, 16'h0000};
    tbl[7]  = '{2'b11, 16'hFFFF, 4'd15, 16'hFFFF};
    tbl[8]  = '{2'b10, 16'h8001, 4'd15, 16'hC000};
    tbl[9]  = '{2'b01, 16'h8000, 4'd15, 16'h0001};
    tbl[10] = '{2'b00, 16'hFFFF, 4'd0,  16'hFFFF};
    tbl[11] = '{2'b10, 16'hA5C3, 4'd8,  16'hC3A5};

    #12;
    chk("reset_ready", 32'(in_ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_data", 32'(out_data), 32'h0);
    rst_n = 1'b1;

    // out_ready while idle is ignored
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("idle_out_ready_valid", 32'(out_valid), 32'd0);
    chk("idle_out_ready_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 12; i++)
      run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].data, tbl[i].cnt, tbl[i].exp);

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  rop;
      logic [15:0] rd;
      logic [3:0]  rc;
      rop = 2'($urandom_range(0, 3));
      rd  = 16'($urandom);
      rc  = 4'($urandom_range(0, 15));
      run_op($sformatf("rand%0d", i), rop, rd, rc, model(rop, rd, rc));
    end

    // Backpressure with a pending request held during DONE
    start_op(2'b00, 16'h0003, 4'd3, lat);
    held = out_data;
    chk("bp_data_first", 32'(held), 32'h0018);
    in_op = 2'b01; in_data = 16'hFF00; in_cnt = 4'd8; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_stable_data", 32'(out_data), 32'(held));
      chk("bp_stable_valid", 32'(out_valid), 32'd1);
      chk("bp_stable_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_after_hs_busy", 32'(busy), 32'd0);
    chk("bp_after_hs_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_next_accept_busy", 32'(busy), 32'd1);
    lat = 0;
    while (!out_valid && lat < 20) begin tick(); lat++; end
    chk("bp_next_lat", 32'(lat), 32'd4);
    chk("bp_next_data", 32'(out_data), 32'h00FF);
    consume();

    // Asynchronous reset during SHIFT stage 2
    chk("pre_reset_last_data", 32'(out_data), 32'h00FF);
    in_op = 2'b00; in_data = 16'h00FF; in_cnt = 4'd15; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(in_ready), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_data", 32'(out_data), 32'h0);
    #3 rst_n = 1'b1;
    run_op("post_reset_sll", 2'b00, 16'h0101, 4'd7, 16'h8080);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
